// File: rtl/mips_datapath_if.sv
// Control bus and unified memory port between the multicycle controller/memory side and the
// datapath. The master side drives controls and memory read data; the datapath is the slave.
interface mips_datapath_if;
  logic        RegWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        PCWrite;
  logic        ALUSrcA;
  logic        Branch;
  logic        MemWrite;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  PCSrc;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic [5:0]  Opcode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport master (
    output RegWrite, RegDst, MemtoReg, PCWrite, ALUSrcA, Branch, MemWrite, IorD, IRWrite,
    output PCSrc, ALUSrcB, ALUOp, mem_rdata, dbg_addr,
    input  Opcode, mem_addr, mem_wdata, mem_we, dbg_data
  );

  modport slave (
    input  RegWrite, RegDst, MemtoReg, PCWrite, ALUSrcA, Branch, MemWrite, IorD, IRWrite,
    input  PCSrc, ALUSrcB, ALUOp, mem_rdata, dbg_addr,
    output Opcode, mem_addr, mem_wdata, mem_we, dbg_data
  );
endinterface

// File: rtl/mips_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, 32x32 register file and ALU, steered
// entirely by the controller's per-cycle selects and enables.
module mips_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  mips_datapath_if.slave  bus
);

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt,
    AluZero
  } alu_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q;
  logic [31:0] mdr_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out_q;
  logic [31:0] rf_q [32];

  logic [4:0]  rs, rt, rd, wr_addr;
  logic [5:0]  funct;
  logic [31:0] rd1, rd2, wr_data;
  logic [31:0] sign_imm;
  logic [31:0] src_a, src_b;
  logic [31:0] alu_result;
  alu_op_e     alu_op;
  logic        zero;
  logic        pc_en;

  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign sign_imm = {{16{ir_q[15]}}, ir_q[15:0]};

  assign rd1 = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  assign wr_addr = bus.RegDst ? rd : rt;
  assign wr_data = bus.MemtoReg ? mdr_q : alu_out_q;

  assign src_a = bus.ALUSrcA ? a_q : pc_q;

  always_comb begin
    src_b = b_q;
    unique case (bus.ALUSrcB)
      2'b00: src_b = b_q;
      2'b01: src_b = 32'd4;
      2'b10: src_b = sign_imm;
      2'b11: src_b = {sign_imm[29:0], 2'b00};
      default: src_b = b_q;
    endcase
  end

  // ALUOp 11 is reserved and behaves as add; unknown functs force a zero result.
  always_comb begin
    alu_op = AluAdd;
    unique case (bus.ALUOp)
      2'b00: alu_op = AluAdd;
      2'b01: alu_op = AluSub;
      2'b10: begin
        case (funct)
          6'b100000: alu_op = AluAdd;
          6'b100010: alu_op = AluSub;
          6'b100100: alu_op = AluAnd;
          6'b100101: alu_op = AluOr;
          6'b101010: alu_op = AluSlt;
          default:   alu_op = AluZero;
        endcase
      end
      2'b11: alu_op = AluAdd;
      default: alu_op = AluAdd;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    unique case (alu_op)
      AluAdd:  alu_result = src_a + src_b;
      AluSub:  alu_result = src_a - src_b;
      AluAnd:  alu_result = src_a & src_b;
      AluOr:   alu_result = src_a | src_b;
      AluSlt:  alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
      AluZero: alu_result = 32'd0;
      default: alu_result = 32'd0;
    endcase
  end

  assign zero  = (alu_result == 32'd0);
  assign pc_en = bus.PCWrite | (bus.Branch & zero);

  always_comb begin
    pc_d = alu_result;
    unique case (bus.PCSrc)
      2'b00: pc_d = alu_result;
      2'b01: pc_d = alu_out_q;
      2'b10: pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      2'b11: pc_d = alu_result;
      default: pc_d = alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      if (pc_en) begin
        pc_q <= pc_d;
      end
      if (bus.IRWrite) begin
        ir_q <= bus.mem_rdata;
      end
      mdr_q     <= bus.mem_rdata;
      a_q       <= rd1;
      b_q       <= rd2;
      alu_out_q <= alu_result;
    end
  end

  // Reads above see the pre-write contents, so A/B capture old values on a same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (bus.RegWrite && (wr_addr != 5'd0)) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  assign bus.Opcode    = ir_q[31:26];
  assign bus.mem_addr  = bus.IorD ? alu_out_q : pc_q;
  assign bus.mem_wdata = b_q;
  assign bus.mem_we    = bus.MemWrite;
  assign bus.dbg_data  = (bus.dbg_addr == 5'd0) ? 32'd0 : rf_q[bus.dbg_addr];

endmodule
